// File: rtl/pwr_seq_master.sv
// ---------------------------------------------------------------------------
// pwr_seq_master
// Central power sequencer. Brings up PCH main power, then CPU, then memory,
// each stage gated on the previous rail's power-good, and shuts the rails
// down in reverse order. Rail faults and power-good timeouts latch a fault
// code. Clearing the fault emits a one-cycle goOut_fltSt pulse that releases
// the sub-blocks' fault latches.
//
// Ports
//   iClk, iRst                       clock, synchronous active-high reset
//   iPwrOnReq / iPwrOffReq           power-up / orderly power-down request
//   iFltClr                          clear the latched fault
//   {PCH,CPU,MEM}_PwrGD              rail power-good (iClk-synchronous)
//   {PCH,CPU,MEM}_PwrFLT             rail fault (iClk-synchronous)
//   PCH_PwrMain, CPU_PwrEN, MEM_PwrEN  registered rail enables
//   goOut_fltSt                      one-cycle fault-release pulse
//   oPwrState                        current state encoding
//   oFltCode                         latched fault cause
//   oSysPwrOk                        high only in RUN
// ---------------------------------------------------------------------------
module pwr_seq_master #(
    parameter int unsigned STAGE_DLY = 16,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iPwrOnReq,
    input  logic       iPwrOffReq,
    input  logic       iFltClr,
    input  logic       PCH_PwrGD,
    input  logic       CPU_PwrGD,
    input  logic       MEM_PwrGD,
    input  logic       PCH_PwrFLT,
    input  logic       CPU_PwrFLT,
    input  logic       MEM_PwrFLT,
    output logic       PCH_PwrMain,
    output logic       CPU_PwrEN,
    output logic       MEM_PwrEN,
    output logic       goOut_fltSt,
    output logic [3:0] oPwrState,
    output logic [2:0] oFltCode,
    output logic       oSysPwrOk
);

    typedef enum logic [3:0] {
        ST_OFF    = 4'd0,
        ST_PCH_UP = 4'd1,
        ST_CPU_UP = 4'd2,
        ST_MEM_UP = 4'd3,
        ST_RUN    = 4'd4,
        ST_MEM_DN = 4'd5,
        ST_CPU_DN = 4'd6,
        ST_PCH_DN = 4'd7,
        ST_FAULT  = 4'd8
    } state_e;

    localparam logic [2:0] CODE_NONE    = 3'd0;
    localparam logic [2:0] CODE_PCH_TO  = 3'd4;
    localparam logic [2:0] CODE_CPU_TO  = 3'd5;
    localparam logic [2:0] CODE_MEM_TO  = 3'd6;
    localparam logic [2:0] CODE_GD_LOST = 3'd7;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         code_q, code_d;
    logic               pch_en_q, pch_en_d;
    logic               cpu_en_q, cpu_en_d;
    logic               mem_en_q, mem_en_d;
    logic               go_q, go_d;
    logic               ok_q, ok_d;

    logic               cnt_timeout;
    logic               cnt_dly_met;
    logic               cnt_dly_eq;
    logic [2:0]         fc;

    // Lowest-numbered asserted fault wins; callers mask rails not yet enabled.
    function automatic logic [2:0] flt_code(input logic p, input logic c, input logic m);
        if (p)      return 3'd1;
        else if (c) return 3'd2;
        else if (m) return 3'd3;
        else        return CODE_NONE;
    endfunction

    assign cnt_timeout = (cnt_q == CNT_W'(TIMEOUT));
    assign cnt_dly_met = (cnt_q >= CNT_W'(STAGE_DLY));
    assign cnt_dly_eq  = (cnt_q == CNT_W'(STAGE_DLY));

    // Next-state, fault-code and registered-output decode
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        go_d    = 1'b0;
        fc      = CODE_NONE;

        unique case (state_q)
            ST_OFF: begin
                if (iPwrOnReq) state_d = ST_PCH_UP;
            end
            ST_PCH_UP: begin
                fc = flt_code(PCH_PwrFLT, 1'b0, 1'b0);
                if (fc != CODE_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = fc;
                end else if (cnt_timeout && !PCH_PwrGD) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_PCH_TO;
                end else if (iPwrOffReq) begin
                    state_d = ST_PCH_DN;
                end else if (PCH_PwrGD && cnt_dly_met) begin
                    state_d = ST_CPU_UP;
                end
            end
            ST_CPU_UP: begin
                fc = flt_code(PCH_PwrFLT, CPU_PwrFLT, 1'b0);
                if (fc != CODE_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = fc;
                end else if (cnt_timeout && !CPU_PwrGD) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_CPU_TO;
                end else if (iPwrOffReq) begin
                    state_d = ST_CPU_DN;
                end else if (CPU_PwrGD && cnt_dly_met) begin
                    state_d = ST_MEM_UP;
                end
            end
            ST_MEM_UP: begin
                fc = flt_code(PCH_PwrFLT, CPU_PwrFLT, MEM_PwrFLT);
                if (fc != CODE_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = fc;
                end else if (cnt_timeout && !MEM_PwrGD) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_MEM_TO;
                end else if (iPwrOffReq) begin
                    state_d = ST_MEM_DN;
                end else if (MEM_PwrGD && cnt_dly_met) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                fc = flt_code(PCH_PwrFLT, CPU_PwrFLT, MEM_PwrFLT);
                if (fc != CODE_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = fc;
                end else if (!(PCH_PwrGD && CPU_PwrGD && MEM_PwrGD)) begin
                    state_d = ST_FAULT;
                    code_d  = CODE_GD_LOST;
                end else if (iPwrOffReq) begin
                    state_d = ST_MEM_DN;
                end
            end
            // Shutdown only watches faults on rails that are still enabled
            ST_MEM_DN: begin
                fc = flt_code(PCH_PwrFLT, CPU_PwrFLT, 1'b0);
                if (fc != CODE_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = fc;
                end else if (cnt_dly_eq) begin
                    state_d = ST_CPU_DN;
                end
            end
            ST_CPU_DN: begin
                fc = flt_code(PCH_PwrFLT, 1'b0, 1'b0);
                if (fc != CODE_NONE) begin
                    state_d = ST_FAULT;
                    code_d  = fc;
                end else if (cnt_dly_eq) begin
                    state_d = ST_PCH_DN;
                end
            end
            ST_PCH_DN: begin
                if (cnt_dly_eq) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (iFltClr) begin
                    state_d = ST_OFF;
                    code_d  = CODE_NONE;
                    go_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_OFF;
                code_d  = CODE_NONE;
            end
        endcase

        // Enables are decoded from the next state so they land with it
        pch_en_d = state_d inside {ST_PCH_UP, ST_CPU_UP, ST_MEM_UP, ST_RUN,
                                   ST_MEM_DN, ST_CPU_DN};
        cpu_en_d = state_d inside {ST_CPU_UP, ST_MEM_UP, ST_RUN, ST_MEM_DN};
        mem_en_d = state_d inside {ST_MEM_UP, ST_RUN};
        ok_d     = (state_d == ST_RUN);

        // Stage counter restarts on every state entry and saturates at TIMEOUT
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_timeout) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            code_q   <= CODE_NONE;
            pch_en_q <= 1'b0;
            cpu_en_q <= 1'b0;
            mem_en_q <= 1'b0;
            go_q     <= 1'b0;
            ok_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            pch_en_q <= pch_en_d;
            cpu_en_q <= cpu_en_d;
            mem_en_q <= mem_en_d;
            go_q     <= go_d;
            ok_q     <= ok_d;
        end
    end

    assign PCH_PwrMain = pch_en_q;
    assign CPU_PwrEN   = cpu_en_q;
    assign MEM_PwrEN   = mem_en_q;
    assign goOut_fltSt = go_q;
    assign oPwrState   = state_q;
    assign oFltCode    = code_q;
    assign oSysPwrOk   = ok_q;

endmodule

// File: doc/pwr_seq_master.md
# pwr_seq_master

Central power-sequencing state machine that drives the master side of the `If_PwrSeq` interface. It brings up PCH main power, then CPU, then memory rails. Each stage waits on the previous rail's power-good, and the block shuts rails down in reverse order. Any rail fault or power-good timeout latches a fault state with a code, and the block releases the sub-blocks' fault latches through a one-cycle `goOut_fltSt` pulse when the fault is cleared.

## Interface
- `STAGE_DLY`, 16: minimum cycles spent in a stage before advancing; also the gap between disables on shutdown.
- `TIMEOUT`, 1000: cycles allowed for a rail's power-good to assert after its enable. Must be greater than `STAGE_DLY`.
- `CNT_W`, `$clog2(TIMEOUT+1)`: stage counter width (derived).
- `iClk`  in  1  system clock. One clock domain.
- `iRst`  in  1  synchronous, active-high reset.
- `iPwrOnReq`  in  1  request power-up (level or pulse; sampled each cycle).
- `iPwrOffReq`  in  1  request orderly power-down.
- `iFltClr`  in  1  clear latched fault.
- `PCH_PwrGD`, `CPU_PwrGD`, `MEM_PwrGD`  in  1 each  rail power-good.
- `PCH_PwrFLT`, `CPU_PwrFLT`, `MEM_PwrFLT`  in  1 each  rail fault.
- `PCH_PwrMain`, `CPU_PwrEN`, `MEM_PwrEN`  out  1 each  rail enables (registered).
- `goOut_fltSt`  out  1  one-cycle pulse that tells the PCH/CPU blocks to leave their fault state.
- `oPwrState`  out  4  current state encoding.
- `oFltCode`  out  3  latched fault cause.
- `oSysPwrOk`  out  1  high only in RUN.

## Operation
- States and encodings:
  - OFF = 0
  - PCH_UP = 1
  - CPU_UP = 2
  - MEM_UP = 3
  - RUN = 4
  - MEM_DN = 5
  - CPU_DN = 6
  - PCH_DN = 7
  - FAULT = 8
- Enables per state:
  - PCH_PwrMain = 1 in PCH_UP through MEM_DN and in CPU_DN.
  - CPU_PwrEN = 1 in CPU_UP through MEM_DN.
  - MEM_PwrEN = 1 in MEM_UP and RUN.
  - All enables are 0 in OFF, PCH_DN and FAULT.
- Stage counter `cnt` resets to 0 on every state entry and increments each cycle. It saturates at `TIMEOUT`.
- OFF: `iPwrOnReq` → PCH_UP. If `iPwrOnReq` and `iPwrOffReq` are both asserted, on wins.
- xx_UP stages (rail = PCH, CPU or MEM), priority highest first:
  1. Fault: the rail's own FLT, or the FLT of any rail already enabled → FAULT.
  2. Timeout: `cnt == TIMEOUT` and rail GD = 0 → FAULT.
  3. Abort: `iPwrOffReq` → the DN state matching the highest enabled rail (MEM_UP→MEM_DN, CPU_UP→CPU_DN, PCH_UP→PCH_DN).
  4. Advance: rail GD = 1 and `cnt >= STAGE_DLY` → next stage (PCH_UP→CPU_UP→MEM_UP→RUN).
- RUN: any FLT, or any GD going low → FAULT. Otherwise `iPwrOffReq` → MEM_DN. `iPwrOnReq` is ignored.
- DN states: after `cnt == STAGE_DLY`, step MEM_DN→CPU_DN→PCH_DN→OFF.
  - GD is not checked during DN states.
  - FLT is checked only for rails whose enable is still 1; such a FLT → FAULT.
  - `iPwrOnReq` is ignored.
- Fault codes, latched on entry to FAULT:
  - 1 = PCH_FLT, 2 = CPU_FLT, 3 = MEM_FLT
  - 4 = PCH GD timeout, 5 = CPU GD timeout, 6 = MEM GD timeout
  - 7 = GD lost in RUN
  - When several causes occur in the same cycle, the lowest code wins.
- FAULT: all enables are 0 and the code is held. `iFltClr` → OFF, with `goOut_fltSt` = 1 for exactly that transition cycle and `oFltCode` cleared to 0 in the same cycle. Request inputs are ignored in FAULT.

## Timing
- Reset values: all outputs 0, state OFF, `cnt` 0.
- All outputs are registered. Each output reflects the new state in the cycle after the deciding input is sampled.
- Power-up latency:
  - The enable rises 1 cycle after the request.
  - Minimum dwell per UP stage is `STAGE_DLY+1` cycles.
  - With power-good already high, RUN is reached `3*(STAGE_DLY+1)+1` cycles after `iPwrOnReq` is sampled.
- Power-down takes `3*(STAGE_DLY+1)` cycles from MEM_DN entry to OFF.
- Fault response: enables drop to 0 one cycle after the FLT or timeout is sampled. This takes priority over every other transition in the same cycle.
- Reset mid-sequence: all enables drop to 0 the cycle after `iRst` is sampled. No reverse ordering and no `goOut_fltSt` pulse.
- GD or FLT inputs must be synchronous to `iClk`; synchronisers are upstream.

## Test plan
All scenarios use `STAGE_DLY=4`, `TIMEOUT=20`.
- **Normal power-up.** All GD tied high; pulse `iPwrOnReq` at cycle 0 → PCH_PwrMain=1 @1, CPU_PwrEN=1 @6, MEM_PwrEN=1 @11, RUN and `oSysPwrOk`=1 @16.
- **CPU power-good timeout.** CPU_PwrGD held low → 21 cycles after CPU_UP entry the block is in FAULT, `oFltCode`=5 and all enables are 0.
- **Simultaneous faults in RUN.** Assert CPU_PwrFLT and MEM_PwrFLT in the same cycle → FAULT with `oFltCode`=2. Then pulse `iFltClr` → one-cycle `goOut_fltSt`, state OFF, `oFltCode`=0.
- **Orderly shutdown.** `iPwrOffReq` in RUN → MEM_PwrEN=0 next cycle, CPU_PwrEN=0 5 cycles later, PCH_PwrMain=0 5 cycles after that, then OFF 5 cycles later.
- **Abort mid power-up.** `iPwrOffReq` in CPU_UP → CPU_DN next cycle (MEM_PwrEN never set), then PCH_DN, then OFF.
- **Reset mid-sequence.** Assert `iRst` in MEM_UP → all outputs 0 the next cycle; also verify `iPwrOnReq` and `iPwrOffReq` together in OFF starts PCH_UP.
